// File: rtl/iob_plic_claimer_if.sv
// IOb request/response bus shared by the PLIC claimer (master) and the PLIC target (slave).
// Requests are valid/address/wdata/wstrb; the one-cycle ready pulse carries rdata back.
interface iob_plic_claimer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic                  valid;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;

  modport master (
    output valid,
    output address,
    output wdata,
    output wstrb,
    input  rdata,
    input  ready
  );

  modport slave (
    input  valid,
    input  address,
    input  wdata,
    input  wstrb,
    output rdata,
    output ready
  );
endinterface

// File: rtl/iob_plic_claimer.sv
// IOb initiator servicing one PLIC target: programs the threshold after reset, then on irq
// claims a source ID, presents it to a handler and writes it back as completion.
module iob_plic_claimer #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned SOURCES        = 8,
  parameter logic [15:0] CLAIM_ADDR     = 16'h0004,
  parameter logic [15:0] THRESHOLD_ADDR = 16'h0000,
  parameter int unsigned THRESHOLD_INIT = 0,
  parameter int unsigned TIMEOUT        = 255,
  localparam int unsigned ID_W          = $clog2(SOURCES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                irq,
  iob_plic_claimer_if.master  bus,
  output logic                id_valid,
  output logic [ID_W-1:0]     id,
  input  logic                id_done,
  output logic                busy,
  output logic                err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CntLimit = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    StInitWr,
    StIdle,
    StClaimRd,
    StServe,
    StCompleteWr
  } state_e;

  state_e              state_q, state_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                id_valid_q, id_valid_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                bus_hit;
  logic                bus_stall;
  logic [CNT_W-1:0]    cnt_inc;
  logic                timeout;
  logic [ID_W-1:0]     claimed_id;

  assign bus_hit    = valid_q && bus.ready;
  assign bus_stall  = valid_q && !bus.ready;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  // A ready arriving on the limit cycle completes the transfer instead of timing out.
  assign timeout    = bus_stall && (cnt_inc == CntLimit);
  assign claimed_id = bus.rdata[ID_W-1:0];

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    address_d  = address_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    id_valid_d = id_valid_q;
    id_d       = id_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;

    if (bus_stall) begin
      cnt_d = cnt_inc;
    end

    unique case (state_q)
      StInitWr: begin
        if (!valid_q) begin
          valid_d   = 1'b1;
          address_d = ADDR_W'(THRESHOLD_ADDR);
          wdata_d   = DATA_W'(THRESHOLD_INIT);
          wstrb_d   = '1;
          cnt_d     = '0;
        end else if (bus_hit) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (irq) begin
          state_d   = StClaimRd;
          valid_d   = 1'b1;
          address_d = ADDR_W'(CLAIM_ADDR);
          wdata_d   = '0;
          wstrb_d   = '0;
          cnt_d     = '0;
        end
      end
      StClaimRd: begin
        if (bus_hit) begin
          valid_d = 1'b0;
          id_d    = claimed_id;
          // ID 0 means nothing was pending (spurious interrupt).
          if (claimed_id == '0) begin
            state_d = StIdle;
          end else begin
            state_d    = StServe;
            id_valid_d = 1'b1;
          end
        end
      end
      StServe: begin
        if (id_done) begin
          state_d    = StCompleteWr;
          id_valid_d = 1'b0;
          valid_d    = 1'b1;
          address_d  = ADDR_W'(CLAIM_ADDR);
          wdata_d    = DATA_W'(id_q);
          wstrb_d    = '1;
          cnt_d      = '0;
        end
      end
      StCompleteWr: begin
        if (bus_hit) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase

    if (timeout) begin
      valid_d    = 1'b0;
      err_d      = 1'b1;
      id_valid_d = 1'b0;
      state_d    = StIdle;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInitWr;
      valid_q    <= 1'b0;
      address_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      id_valid_q <= 1'b0;
      id_q       <= '0;
      busy_q     <= 1'b1;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      address_q  <= address_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      id_valid_q <= id_valid_d;
      id_q       <= id_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.valid   = valid_q;
  assign bus.address = address_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign id_valid    = id_valid_q;
  assign id          = id_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_iob_plic_claimer.sv
// Directed bench for iob_plic_claimer: a hand-driven IOb responder plus handler stimulus,
// with every expectation written out as a constant.
module tb_iob_plic_claimer;

  localparam int unsigned ID_W = 4;

  logic            clk;
  logic            rst;
  logic            irq;
  logic            id_valid;
  logic [ID_W-1:0] id;
  logic            id_done;
  logic            busy;
  logic            err;

  int n_cmp;
  int n_bad;

  iob_plic_claimer_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  iob_plic_claimer #(
    .ADDR_W        (16),
    .DATA_W        (32),
    .SOURCES       (8),
    .CLAIM_ADDR    (16'h0004),
    .THRESHOLD_ADDR(16'h0000),
    .THRESHOLD_INIT(0),
    .TIMEOUT       (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .irq     (irq),
    .bus     (bus.master),
    .id_valid(id_valid),
    .id      (id),
    .id_done (id_done),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a request, checks it, stalls dly cycles, then pulses ready.
  task automatic serve_req(input string tag, input logic [15:0] ea, input logic [31:0] ew,
                           input logic [3:0] es, input int dly, input logic [31:0] rd);
    int n;
    n = 0;
    while (!bus.valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(bus.valid), 32'd1);
    check({tag, "_addr"}, 32'(bus.address), 32'(ea));
    check({tag, "_wstrb"}, 32'(bus.wstrb), 32'(es));
    if (es != 4'h0) check({tag, "_wdata"}, bus.wdata, ew);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, 32'(bus.valid), 32'd1);
    end
    bus.rdata = rd;
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    bus.rdata = '0;
    check({tag, "_drop"}, 32'(bus.valid), 32'd0);
  endtask

  // Called on the cycle right after the claim response.
  task automatic handle_id(input string tag, input logic [ID_W-1:0] eid);
    check({tag, "_idv"}, 32'(id_valid), 32'd1);
    check({tag, "_id"}, 32'(id), 32'(eid));
    @(negedge clk);
    check({tag, "_idv_hold"}, 32'(id_valid), 32'd1);
    check({tag, "_nobus"}, 32'(bus.valid), 32'd0);
    id_done = 1'b1;
    @(negedge clk);
    id_done = 1'b0;
    check({tag, "_idv_off"}, 32'(id_valid), 32'd0);
    check({tag, "_wr_start"}, 32'(bus.valid), 32'd1);
  endtask

  initial begin
    int n_hi;
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    irq       = 1'b0;
    id_done   = 1'b0;
    bus.ready = 1'b0;
    bus.rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_addr", 32'(bus.address), 32'd0);
    check("rst_idv", 32'(id_valid), 32'd0);
    check("rst_id", 32'(id), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;

    // 1: threshold write after reset
    serve_req("init", 16'h0000, 32'h0, 4'hF, 2, 32'h0);
    check("init_busy", 32'(busy), 32'd0);

    // 2: normal claim/complete of ID 5
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    check("t2_busy", 32'(busy), 32'd1);
    serve_req("t2_rd", 16'h0004, 32'h0, 4'h0, 1, 32'h5);
    handle_id("t2", 4'd5);
    serve_req("t2_wr", 16'h0004, 32'h5, 4'hF, 0, 32'h0);
    check("t2_busy_end", 32'(busy), 32'd0);

    // 3: spurious claim; the set bit lies above ID_W so the ID is 0
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    serve_req("t3_rd", 16'h0004, 32'h0, 4'h0, 0, 32'h0000_0010);
    check("t3_idv", 32'(id_valid), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("t3_no_wr", 32'(bus.valid), 32'd0);
    check("t3_idv_late", 32'(id_valid), 32'd0);

    // 4: ready withheld until the timeout fires
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    n_hi = 0;
    while (bus.valid && n_hi < 20) begin
      n_hi++;
      @(negedge clk);
    end
    check("t4_valid_cycles", 32'(n_hi), 32'd4);
    check("t4_err", 32'(err), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t4_err_pulse", 32'(err), 32'd0);
    check("t4_idle", 32'(bus.valid), 32'd0);

    // 5: irq held over completion -> back-to-back claims, upper rdata bits ignored
    irq = 1'b1;
    @(negedge clk);
    serve_req("t5_rd1", 16'h0004, 32'h0, 4'h0, 0, 32'hABCD_0006);
    handle_id("t5a", 4'd6);
    serve_req("t5_wr1", 16'h0004, 32'h6, 4'hF, 1, 32'h0);
    @(negedge clk);
    check("t5_reclaim", 32'(bus.valid), 32'd1);
    check("t5_reclaim_addr", 32'(bus.address), 32'h4);
    serve_req("t5_rd2", 16'h0004, 32'h0, 4'h0, 0, 32'h3);
    irq = 1'b0;
    handle_id("t5b", 4'd3);
    serve_req("t5_wr2", 16'h0004, 32'h3, 4'hF, 0, 32'h0);

    // 6: reset while serving ID 7
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    serve_req("t6_rd", 16'h0004, 32'h0, 4'h0, 0, 32'h7);
    check("t6_idv", 32'(id_valid), 32'd1);
    check("t6_id", 32'(id), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_idv", 32'(id_valid), 32'd0);
    check("t6_rst_id", 32'(id), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd1);
    serve_req("t6_init", 16'h0000, 32'h0, 4'hF, 1, 32'h0);
    check("t6_busy_end", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
